// File: rtl/alu_exec_unit.sv
// Execute stage behind the ALU control decoder. Single-cycle add/sub/and/or/nor/slt
// and an optional shift-add unsigned multiply, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       ALU_OP,
    input  logic [5:0]       FUNCTION,
    input  logic [WIDTH-1:0] OPERAND_A,
    input  logic [WIDTH-1:0] OPERAND_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             ZERO,
    output logic             ILLEGAL,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MULTU, OP_ILL
    } op_e;
    typedef enum logic {IDLE, MUL} state_e;

    state_e             state;
    op_e                op;
    logic [WIDTH-1:0]   alu_res;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic               accept;

    assign IN_READY = (state == IDLE) && (!OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    // NOTE: op gets a default before the case so every decode path assigns it; no latch.
    always_comb begin
        op = OP_ILL;
        case (ALU_OP)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (FUNCTION)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b011001: op = MUL_EN ? OP_MULTU : OP_ILL;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = OPERAND_A + OPERAND_B;
            OP_SUB:  alu_res = OPERAND_A - OPERAND_B;
            OP_AND:  alu_res = OPERAND_A & OPERAND_B;
            OP_OR:   alu_res = OPERAND_A | OPERAND_B;
            OP_NOR:  alu_res = ~(OPERAND_A | OPERAND_B);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OPERAND_A) < $signed(OPERAND_B))};
            default: alu_res = '0;
        endcase
    end

    // Upper half accumulates the multiplicand, lower half shifts out multiplier bits.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_next = {mul_sum, prod[WIDTH-1:1]};

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            RESULT_HI <= '0;
            ZERO      <= 1'b0;
            ILLEGAL   <= 1'b0;
            BUSY      <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            prod      <= '0;
        end else begin
            if (OUT_VALID && OUT_READY)
                OUT_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MULTU) begin
                            mcand <= OPERAND_A;
                            prod  <= {{WIDTH{1'b0}}, OPERAND_B};
                            count <= CW'(WIDTH);
                            BUSY  <= 1'b1;
                            state <= MUL;
                        end else begin
                            RESULT    <= alu_res;
                            RESULT_HI <= '0;
                            ZERO      <= (alu_res == '0);
                            ILLEGAL   <= (op == OP_ILL);
                            OUT_VALID <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod  <= prod_next;
                    count <= count - CW'(1);
                    // Last add/shift and writeback share an edge: WIDTH+1 cycles accept-to-valid.
                    if (count == CW'(1)) begin
                        RESULT    <= prod_next[WIDTH-1:0];
                        RESULT_HI <= prod_next[2*WIDTH-1:WIDTH];
                        ZERO      <= (prod_next[WIDTH-1:0] == '0);
                        ILLEGAL   <= 1'b0;
                        OUT_VALID <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results queued on accept, compared on transfer.
`timescale 1ns/1ps
module tb_alu_exec_unit;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR  = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010,
                           F_MUL = 6'b011001;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid_nm = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  func = 6'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        in_ready, out_valid, zero, illegal, busy;
    logic [31:0] result, result_hi;
    logic        in_ready_nm, out_valid_nm, zero_nm, illegal_nm, busy_nm;
    logic [31:0] result_nm, result_hi_nm;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    time  t0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .ALU_OP(alu_op), .FUNCTION(func), .OPERAND_A(op_a), .OPERAND_B(op_b),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .RESULT(result),
        .RESULT_HI(result_hi), .ZERO(zero), .ILLEGAL(illegal), .BUSY(busy)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid_nm), .IN_READY(in_ready_nm),
        .ALU_OP(alu_op), .FUNCTION(func), .OPERAND_A(op_a), .OPERAND_B(op_b),
        .OUT_VALID(out_valid_nm), .OUT_READY(1'b1), .RESULT(result_nm),
        .RESULT_HI(result_hi_nm), .ZERO(zero_nm), .ILLEGAL(illegal_nm), .BUSY(busy_nm)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        case (op)
            2'b00: e.res = a + b;
            2'b01: e.res = a - b;
            2'b10: begin
                case (fn)
                    F_ADD: e.res = a + b;
                    F_SUB: e.res = a - b;
                    F_AND: e.res = a & b;
                    F_OR:  e.res = a | b;
                    F_NOR: e.res = ~(a | b);
                    F_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    F_MUL: begin
                        p     = {32'b0, a} * {32'b0, b};
                        e.res = p[31:0];
                        e.hi  = p[63:32];
                    end
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Drive one request, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        alu_op = op; func = fn; op_a = a; op_b = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) sb.push_back(model(op, fn, a, b));
        else check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("result_hi", result_hi, e.hi);
                check("zero", zero, e.zero);
                check("illegal", illegal, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", {result_hi, result}, 64'd0);
        check("rst_flags", {zero, illegal, busy}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        // Test 1: R-type add, latency 1
        send(2'b10, F_ADD, 32'd7, 32'd5);
        check("t1_latency", out_valid, 1'b1);
        drain();

        // Test 2: sub to zero, slt both ways, logic ops, wraparound
        send(2'b01, 6'b0, 32'd5, 32'd5);
        send(2'b10, F_SLT, 32'hFFFF_FFFF, 32'd1);
        send(2'b10, F_SLT, 32'd1, 32'hFFFF_FFFF);
        send(2'b10, F_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        send(2'b10, F_OR,  32'hF000_0001, 32'h0000_0F10);
        send(2'b10, F_NOR, 32'h0000_0000, 32'h0000_0000);
        send(2'b00, 6'b0, 32'hFFFF_FFFF, 32'd1);
        send(2'b10, F_SUB, 32'd0, 32'd1);
        drain();

        // Throughput: four accepts in four cycles with OUT_READY high
        t0 = $time;
        for (int i = 0; i < 4; i++) send(2'b00, 6'b0, $urandom, $urandom);
        check("throughput_cycles", ($time - t0) / 10, 4);
        drain();

        // Test 3: multu 0xFFFFFFFF * 2, busy for 32 cycles, valid in cycle 33
        send(2'b10, F_MUL, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 32; i++) begin
            check("mul_busy_window", {busy, in_ready, out_valid}, 3'b100);
            @(posedge clk);
            #1;
        end
        check("mul_done", {busy, out_valid}, 2'b01);
        drain();
        send(2'b10, F_MUL, $urandom, $urandom);
        send(2'b10, F_MUL, 32'd0, 32'h1234_5678);
        drain();

        // Test 4: backpressure for 3 cycles with a second add waiting
        out_ready = 1'b0;
        send(2'b00, 6'b0, 32'd1, 32'd2);
        alu_op = 2'b00; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_hold", {out_valid, result}, {1'b1, 32'd3});
            op_a = op_a + 32'd1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, 6'b0, 32'd10, 32'd20);
        send(2'b10, F_SUB, 32'd100, 32'd1);
        drain();

        // Test 5: illegal decodes, latency 1
        send(2'b10, 6'b000000, 32'd9, 32'd9);
        check("t5_latency", {out_valid, illegal}, 2'b11);
        send(2'b11, F_ADD, 32'd9, 32'd9);
        drain();
        alu_op = 2'b10; func = F_MUL; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
        in_valid_nm = 1'b1;
        @(posedge clk);
        #1;
        in_valid_nm = 1'b0;
        check("nomul_valid_illegal", {out_valid_nm, illegal_nm, busy_nm}, 3'b110);
        check("nomul_result", {result_hi_nm, result_nm}, 64'd0);

        // Test 6: reset 10 cycles into a multu
        send(2'b10, F_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_mul", {out_valid, busy}, 2'b00);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1'b1);
        send(2'b10, F_ADD, 32'd40, 32'd2);
        check("post_rst_latency", out_valid, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
